// File: rtl/te_round_sched_if.sv
// te_round_sched_if: finder/correlator handshake bundle between the round scheduler and its datapath
//   master (scheduler): drives latch_enable_channel, start_find, corr_start, corr_ch_en
//   slave  (datapath) : drives find_channel_done, physical_channel_en, channel_remain, corr_done
interface te_round_sched_if;
   logic        latch_enable_channel;
   logic        start_find;
   logic        find_channel_done;
   logic [3:0]  physical_channel_en;
   logic [31:0] channel_remain;
   logic        corr_start;
   logic [3:0]  corr_ch_en;
   logic        corr_done;
   modport master (
      output latch_enable_channel, start_find, corr_start, corr_ch_en,
      input  find_channel_done, physical_channel_en, channel_remain, corr_done
   );
   modport slave (
      input  latch_enable_channel, start_find, corr_start, corr_ch_en,
      output find_channel_done, physical_channel_en, channel_remain, corr_done
   );
endinterface

// File: rtl/te_round_sched.sv
// te_round_sched: sequences one correlation round over 32 channels in batches of up to 4
//   clk, rst         : clock, asynchronous active-high reset
//   round_start_i    : request a new round (ignored and flagged as overrun while busy)
//   round_abort_i    : terminate the round in progress without round_done
//   overrun_clr_i    : clears overrun_o and corr_timeout_o
//   dp               : finder/correlator handshake (te_round_sched_if.master)
//   busy_o           : round in progress
//   round_done_o     : one-cycle pulse at round end
//   batch_count_o    : batches correlated in the last completed round
//   overrun_o        : sticky, round_start arrived while busy
//   corr_timeout_o   : sticky, correlator timed out (only with TE_ROUND_TIMEOUT_EN)
// Optional feature: define TE_ROUND_TIMEOUT_EN to abort a WAIT_CORR that lasts TIMEOUT_CYCLES.
module te_round_sched #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             round_start_i,
   input  logic             round_abort_i,
   input  logic             overrun_clr_i,
   te_round_sched_if.master dp,
   output logic             busy_o,
   output logic             round_done_o,
   output logic [3:0]       batch_count_o,
   output logic             overrun_o,
   output logic             corr_timeout_o
);
   typedef enum logic [2:0] {IDLE, LATCH, FIND, WAIT_FIND, CORR, WAIT_CORR, DONE} state_t;
   state_t     state_q, state_d;
   logic [3:0] ch_en_q, ch_en_d;
   logic [3:0] bcnt_q, bcnt_d;
   logic [3:0] batch_count_q, batch_count_d;
   logic       overrun_q, overrun_d;
   logic       abort;
   logic       expire;
   // a start arriving together with an abort in IDLE wins, so abort only counts once busy
   assign abort = round_abort_i && state_q != IDLE;
`ifdef TE_ROUND_TIMEOUT_EN
   logic [15:0] tmr_q, tmr_d;
   logic        timeout_q, timeout_d;
   // a corr_done in the expiry cycle is a normal completion
   assign expire = state_q == WAIT_CORR && !dp.corr_done && tmr_q == 16'(TIMEOUT_CYCLES - 1);
   always_comb begin
      tmr_d     = state_q == CORR ? 16'd0 : state_q == WAIT_CORR ? tmr_q + 16'd1 : tmr_q;
      timeout_d = (expire && !abort) || (timeout_q && !overrun_clr_i);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         timeout_q <= timeout_d;
      end
   end
   assign corr_timeout_o = timeout_q;
`else
   logic unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES == 0;
   assign expire         = 1'b0;
   assign corr_timeout_o = 1'b0;
`endif
   always_comb begin
      state_d       = state_q;
      ch_en_d       = ch_en_q;
      bcnt_d        = bcnt_q;
      batch_count_d = batch_count_q;
      overrun_d     = (round_start_i && state_q != IDLE) || (overrun_q && !overrun_clr_i);
      case (state_q)
         IDLE:      state_d = round_start_i ? LATCH : IDLE;
         LATCH: begin
            bcnt_d  = '0;
            state_d = FIND;
         end
         FIND:      state_d = WAIT_FIND;
         WAIT_FIND: begin
            if (dp.find_channel_done) begin
               if (dp.physical_channel_en == 4'd0) begin
                  state_d = DONE;
               end else begin
                  ch_en_d = dp.physical_channel_en;
                  bcnt_d  = bcnt_q == 4'hF ? bcnt_q : bcnt_q + 4'd1;
                  state_d = CORR;
               end
            end
         end
         CORR:      state_d = WAIT_CORR;
         WAIT_CORR: begin
            if (dp.corr_done) state_d = dp.channel_remain == 32'd0 ? DONE : FIND;
            else if (expire) state_d = DONE;
         end
         DONE: begin
            batch_count_d = bcnt_q;
            state_d       = IDLE;
         end
         default:   state_d = IDLE;
      endcase
      if (abort) begin
         state_d       = IDLE;
         ch_en_d       = ch_en_q;
         batch_count_d = batch_count_q;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ch_en_q       <= '0;
         bcnt_q        <= '0;
         batch_count_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_en_q       <= ch_en_d;
         bcnt_q        <= bcnt_d;
         batch_count_q <= batch_count_d;
         overrun_q     <= overrun_d;
      end
   end
   assign dp.latch_enable_channel = state_q == LATCH;
   assign dp.start_find           = state_q == FIND;
   assign dp.corr_start           = state_q == CORR;
   assign dp.corr_ch_en           = ch_en_q;
   assign busy_o                  = state_q != IDLE;
   assign round_done_o            = state_q == DONE;
   assign batch_count_o           = batch_count_q;
   assign overrun_o               = overrun_q;
endmodule

// File: tb/tb_te_round_sched.sv
// tb_te_round_sched: directed bench for te_round_sched with finder/correlator models and a
// corr_ch_en scoreboard (expected batches queued at round start, popped at each corr_start)
module tb_te_round_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic round_start = 1'b0, round_abort = 1'b0, overrun_clr = 1'b0;
   logic busy, round_done, overrun, corr_timeout;
   logic [3:0] batch_count;
   te_round_sched_if dp_if ();
   te_round_sched #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .round_start_i(round_start), .round_abort_i(round_abort),
      .overrun_clr_i(overrun_clr), .dp(dp_if), .busy_o(busy), .round_done_o(round_done),
      .batch_count_o(batch_count), .overrun_o(overrun), .corr_timeout_o(corr_timeout)
   );
   always #5 clk = ~clk;
   int vec = 0, err = 0, cyc = 0, rd_n = 0, rd_cyc = 0;
   int fc = 0, cc = 0, corr_lat = 2;
   bit withhold = 1'b0;
   logic [31:0] en_word = '0, rem;
   logic [3:0] exp_q[$];
   int cs_cyc[$];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   always @(posedge clk) cyc++;
   // finder answers 3 cycles after start_find; correlator answers corr_lat cycles after corr_start
   always @(negedge clk) begin
      if (rst) begin
         fc = 0;
         cc = 0;
         dp_if.find_channel_done   = 1'b0;
         dp_if.corr_done           = 1'b0;
         dp_if.physical_channel_en = '0;
         dp_if.channel_remain      = '0;
      end else begin
         dp_if.find_channel_done = 1'b0;
         dp_if.corr_done         = 1'b0;
         if (dp_if.latch_enable_channel) begin
            rem = en_word;
            dp_if.channel_remain = en_word;
         end
         if (fc > 0) begin
            fc--;
            if (fc == 0) begin
               automatic int k = 0;
               automatic logic [3:0] en = '0;
               for (int b = 0; b < 32 && k < 4; b++) if (rem[b]) begin
                  rem[b] = 1'b0;
                  en[k]  = 1'b1;
                  k++;
               end
               dp_if.physical_channel_en = en;
               dp_if.channel_remain      = rem;
               dp_if.find_channel_done   = 1'b1;
            end
         end
         if (dp_if.start_find) fc = 3;
         if (cc > 0) begin
            cc--;
            if (cc == 0 && !withhold) dp_if.corr_done = 1'b1;
         end
         if (dp_if.corr_start) cc = corr_lat;
      end
   end
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (dp_if.corr_start) begin
            cs_cyc.push_back(cyc);
            chk("corr_start_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("corr_ch_en", 32'(dp_if.corr_ch_en), 32'(exp_q.pop_front()));
         end
         if (round_done) begin
            rd_n++;
            rd_cyc = cyc;
         end
      end
   end
   task automatic start_round(input logic [31:0] w);
      en_word = w;
      cs_cyc.delete();
      @(negedge clk) round_start = 1'b1;
      @(negedge clk) round_start = 1'b0;
   endtask
   task automatic wait_rd(input string tag);
      automatic int s = rd_n;
      for (int i = 0; i < 400 && rd_n == s; i++) @(negedge clk);
      chk(tag, 32'(rd_n - s), 1);
   endtask
   task automatic wait_cs(input int n);
      for (int i = 0; i < 200 && cs_cyc.size() < n; i++) @(negedge clk);
      chk("corr_start_seen", 32'(cs_cyc.size() >= n), 1);
   endtask
   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_round_done"}, 32'(round_done), 0);
      chk({tag, "_batch_count"}, 32'(batch_count), 0);
      chk({tag, "_overrun"}, 32'(overrun), 0);
      chk({tag, "_corr_timeout"}, 32'(corr_timeout), 0);
      chk({tag, "_corr_ch_en"}, 32'(dp_if.corr_ch_en), 0);
      chk({tag, "_latch"}, 32'(dp_if.latch_enable_channel), 0);
      chk({tag, "_start_find"}, 32'(dp_if.start_find), 0);
      chk({tag, "_corr_start"}, 32'(dp_if.corr_start), 0);
   endtask
   initial begin
      automatic int f, bad;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      // one batch: channels 0,1,4 map onto three physical channels
      exp_q.push_back(4'b0111);
      start_round(32'h0000_0013);
      chk("t1_latch", 32'(dp_if.latch_enable_channel), 1);
      chk("t1_busy", 32'(busy), 1);
      @(negedge clk);
      chk("t1_start_find", 32'(dp_if.start_find), 1);
      chk("t1_latch_off", 32'(dp_if.latch_enable_channel), 0);
      wait_rd("t1_round_done");
      @(negedge clk);
      chk("t1_round_done_pulse", 32'(round_done), 0);
      chk("t1_busy_low", 32'(busy), 0);
      chk("t1_batch_count", 32'(batch_count), 1);
      chk("t1_batches", 32'(cs_cyc.size()), 1);
      // all 32 channels: 8 full batches, 7 cycles between corr_start pulses
      repeat (8) exp_q.push_back(4'hF);
      start_round(32'hFFFF_FFFF);
      wait_rd("t2_round_done");
      @(negedge clk);
      chk("t2_batch_count", 32'(batch_count), 8);
      chk("t2_batches", 32'(cs_cyc.size()), 8);
      bad = 0;
      for (int i = 1; i < cs_cyc.size(); i++) if (cs_cyc[i] - cs_cyc[i-1] != 7) bad++;
      chk("t2_spacing", 32'(bad), 0);
      if (cs_cyc.size() > 0) chk("t2_done_latency", 32'(rd_cyc - cs_cyc[cs_cyc.size()-1]), 3);
      // abort during WAIT_CORR keeps the previous batch_count
      exp_q.push_back(4'b0111);
      f = rd_n;
      start_round(32'h0000_0013);
      wait_cs(1);
      @(negedge clk) round_abort = 1'b1;
      @(negedge clk) round_abort = 1'b0;
      chk("t5_busy", 32'(busy), 0);
      chk("t5_round_done", 32'(round_done), 0);
      repeat (10) @(negedge clk);
      chk("t5_no_round_done", 32'(rd_n - f), 0);
      chk("t5_batch_count", 32'(batch_count), 8);
      exp_q.push_back(4'b0111);
      start_round(32'h0000_0013);
      wait_rd("t5_restart_done");
      @(negedge clk);
      chk("t5_restart_count", 32'(batch_count), 1);
      // empty enable word
      start_round(32'h0);
      @(negedge clk);
      chk("t3_start_find", 32'(dp_if.start_find), 1);
      f = cyc;
      wait_rd("t3_round_done");
      chk("t3_done_latency", 32'(rd_cyc - f), 4);
      @(negedge clk);
      chk("t3_batch_count", 32'(batch_count), 0);
      chk("t3_batches", 32'(cs_cyc.size()), 0);
      // round_start while busy sets overrun without disturbing the round
      corr_lat = 4;
      exp_q.push_back(4'b0111);
      start_round(32'h0000_0013);
      wait_cs(1);
      @(negedge clk) round_start = 1'b1;
      @(negedge clk) round_start = 1'b0;
      chk("t4_overrun", 32'(overrun), 1);
      chk("t4_busy", 32'(busy), 1);
      wait_rd("t4_round_done");
      @(negedge clk);
      chk("t4_batch_count", 32'(batch_count), 1);
      chk("t4_overrun_sticky", 32'(overrun), 1);
      overrun_clr = 1'b1;
      @(negedge clk) overrun_clr = 1'b0;
      chk("t4_overrun_clr", 32'(overrun), 0);
      exp_q.push_back(4'b0111);
      start_round(32'h0000_0013);
      wait_cs(1);
      @(negedge clk) begin
         round_start = 1'b1;
         overrun_clr = 1'b1;
      end
      @(negedge clk) begin
         round_start = 1'b0;
         overrun_clr = 1'b0;
      end
      chk("t4_set_wins", 32'(overrun), 1);
      wait_rd("t4b_round_done");
      corr_lat = 2;
      overrun_clr = 1'b1;
      @(negedge clk) overrun_clr = 1'b0;
`ifdef TE_ROUND_TIMEOUT_EN
      // correlator never answers: DONE after 16 WAIT_CORR cycles
      withhold = 1'b1;
      exp_q.push_back(4'b0111);
      start_round(32'h0000_0013);
      wait_rd("t6_round_done");
      if (cs_cyc.size() > 0) chk("t6_timeout_latency", 32'(rd_cyc - cs_cyc[0]), 17);
      @(negedge clk);
      chk("t6_corr_timeout", 32'(corr_timeout), 1);
      chk("t6_batch_count", 32'(batch_count), 1);
      withhold = 1'b0;
      overrun_clr = 1'b1;
      @(negedge clk) overrun_clr = 1'b0;
      chk("t6_timeout_clr", 32'(corr_timeout), 0);
`else
      chk("t6_corr_timeout_tied", 32'(corr_timeout), 0);
`endif
      // asynchronous reset mid-round
      repeat (8) exp_q.push_back(4'hF);
      start_round(32'hFFFF_FFFF);
      @(negedge clk) round_start = 1'b1;
      @(negedge clk) round_start = 1'b0;
      wait_cs(2);
      @(negedge clk);
      chk("t7_pre_overrun", 32'(overrun), 1);
      chk("t7_pre_ch_en", 32'(dp_if.corr_ch_en), 32'hF);
      #1 rst = 1'b1;
      #1 chk_all_zero("t7_async");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(4'b0111);
      start_round(32'h0000_0013);
      wait_rd("t7_recover_done");
      @(negedge clk);
      chk("t7_recover_count", 32'(batch_count), 1);
      chk("t7_queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
